// File: rtl/tpu_instr_sequencer.sv
// tpu_instr_sequencer
// Fetches 68-bit instructions from a small host-loaded memory and turns them
// into UB-read requests, systolic switch pulses and VPU routing selects.
// Instruction word: [67:66] opcode, [65] transpose, [64] switch,
// [63:60] pathway, [59:51] ptr_select, [50:48] reserved, [47:32] addr,
// [31:16] row_size, [15:0] col_size.
// Host write handshake: a write is taken on a rising edge where
// instr_wr_en && instr_wr_ready; instr_wr_ready is simply !busy, so writes
// presented while the sequencer runs are dropped, never stalled.
module tpu_instr_sequencer #(
    parameter int IMEM_DEPTH = 32,
    localparam int PC_W = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_wr_en,
    input  logic [PC_W-1:0] instr_wr_addr,
    input  logic [67:0]     instr_wr_data,
    output logic            instr_wr_ready,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            stop,
    output logic            busy,
    output logic            done,
    output logic            ub_rd_start_in,
    output logic            ub_rd_transpose,
    output logic [8:0]      ub_ptr_select,
    output logic [15:0]     ub_rd_addr_in,
    output logic [15:0]     ub_rd_row_size,
    output logic [15:0]     ub_rd_col_size,
    output logic            sys_switch_in,
    output logic [3:0]      vpu_data_pathway
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ISSUE = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;

    logic [67:0] mem [IMEM_DEPTH];
    logic [67:0] rdata_q;

    logic issue_fire;
    logic done_fire;

    // decoded view of the word fetched for the current EXEC cycle
    logic [1:0]  dec_op;
    logic        dec_transpose;
    logic        dec_switch;
    logic [3:0]  dec_pathway;
    logic [8:0]  dec_ptr;
    logic [15:0] dec_addr;
    logic [15:0] dec_row;
    logic [15:0] dec_col;
    logic        unused_rsv;

    // registered outputs
    logic        start_pulse_q;
    logic        switch_pulse_q;
    logic        done_pulse_q;
    logic        transpose_q;
    logic [8:0]  ptr_q;
    logic [15:0] addr_q;
    logic [15:0] row_q;
    logic [15:0] col_q;
    logic [3:0]  pathway_q;

    assign dec_op        = rdata_q[67:66];
    assign dec_transpose = rdata_q[65];
    assign dec_switch    = rdata_q[64];
    assign dec_pathway   = rdata_q[63:60];
    assign dec_ptr       = rdata_q[59:51];
    assign dec_addr      = rdata_q[47:32];
    assign dec_row       = rdata_q[31:16];
    assign dec_col       = rdata_q[15:0];
    assign unused_rsv    = ^rdata_q[50:48];

    // instruction memory: host writes only while idle, synchronous read at pc
    always_ff @(posedge clk) begin
        if (instr_wr_en && (state_q == S_IDLE)) begin
            mem[instr_wr_addr] <= instr_wr_data;
        end
        rdata_q <= mem[pc_q];
    end

    // state, pc and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state logic; stop outranks every transition including start
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        issue_fire = 1'b0;
        done_fire  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d    = start_pc;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    case (dec_op)
                        OP_NOP: begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_FETCH;
                        end
                        OP_ISSUE: begin
                            issue_fire = 1'b1;
                            pc_d       = pc_q + 1'b1;
                            state_d    = S_FETCH;
                        end
                        OP_WAIT: begin
                            if (dec_addr == 16'd0) begin
                                pc_d    = pc_q + 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                cnt_d   = dec_addr;
                                state_d = S_WAIT;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
                S_WAIT: begin
                    // counter was loaded with N, so N cycles are spent here
                    if (cnt_q <= 16'd1) begin
                        cnt_d   = '0;
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_fire = 1'b1;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // output registers: one-cycle pulses plus fields held from the last ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_pulse_q  <= 1'b0;
            switch_pulse_q <= 1'b0;
            done_pulse_q   <= 1'b0;
            transpose_q    <= 1'b0;
            ptr_q          <= '0;
            addr_q         <= '0;
            row_q          <= '0;
            col_q          <= '0;
            pathway_q      <= '0;
        end else begin
            start_pulse_q  <= issue_fire;
            switch_pulse_q <= issue_fire & dec_switch;
            done_pulse_q   <= done_fire;
            if (issue_fire) begin
                transpose_q <= dec_transpose;
                ptr_q       <= dec_ptr;
                addr_q      <= dec_addr;
                row_q       <= dec_row;
                col_q       <= dec_col;
                pathway_q   <= dec_pathway;
            end
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign instr_wr_ready   = (state_q == S_IDLE);
    assign done             = done_pulse_q;
    assign ub_rd_start_in   = start_pulse_q;
    assign sys_switch_in    = switch_pulse_q;
    assign ub_rd_transpose  = transpose_q;
    assign ub_ptr_select    = ptr_q;
    assign ub_rd_addr_in    = addr_q;
    assign ub_rd_row_size   = row_q;
    assign ub_rd_col_size   = col_q;
    assign vpu_data_pathway = pathway_q;

endmodule

// File: doc/tpu_instr_sequencer.md
TPU_INSTR_SEQUENCER -- requirements
Module: tpu_instr_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 32, meaning instruction memory entries (power of two); PC_W = log2(IMEM_DEPTH).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port instr_wr_en  input  1  host instruction write strobe.
REQ-005 SHALL have port instr_wr_addr  input  PC_W  write address.
REQ-006 SHALL have port instr_wr_data  input  68  instruction word.
REQ-007 SHALL have port instr_wr_ready  output  1  high when writes are accepted (not busy).
REQ-008 SHALL have ports start  input  1, start_pc  input  PC_W, stop  input  1  (run control).
REQ-009 SHALL have ports busy  output  1, done  output  1  (one-cycle pulse on HALT).
REQ-010 SHALL have outputs ub_rd_start_in 1, ub_rd_transpose 1, ub_ptr_select 9, ub_rd_addr_in 16, ub_rd_row_size 16, ub_rd_col_size 16, sys_switch_in 1, vpu_data_pathway 4, all registered, driving the TPU UB-read, switch and VPU-routing inputs.

Function
REQ-011 Instruction word: [67:66] opcode, [65] transpose, [64] switch, [63:60] pathway, [59:51] ptr_select, [50:48] reserved (ignored), [47:32] addr, [31:16] row_size, [15:0] col_size.
REQ-012 Opcodes: 00 NOP, 01 ISSUE, 10 WAIT (count = addr field), 11 HALT.
REQ-013 Memory: write when instr_wr_en && !busy; writes while busy dropped, no memory change; read synchronous, 1-cycle latency.
REQ-014 States: IDLE, FETCH, EXEC, WAIT, DONE; busy = state != IDLE.
REQ-015 IDLE: start sampled high at edge k -> pc <= start_pc, FETCH; start ignored in all other states.
REQ-016 FETCH: present mem address pc -> EXEC next edge.
REQ-017 EXEC NOP: pc <= pc+1, FETCH.
REQ-018 EXEC ISSUE: at that edge register all fields; ub_rd_start_in high exactly one cycle; sys_switch_in high same cycle iff switch bit set; pc <= pc+1, FETCH.
REQ-019 From start at edge k, an ISSUE at start_pc drives ub_rd_start_in high from edge k+2 to k+3; back-to-back ISSUEs pulse every 2 cycles.
REQ-020 ub_rd_transpose, ub_ptr_select, ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size, vpu_data_pathway hold last-issued value until next ISSUE or reset.
REQ-021 EXEC WAIT: count 0 -> behaves as NOP; count N>0 -> WAIT state for exactly N cycles, then pc <= pc+1, FETCH.
REQ-022 EXEC HALT: -> DONE; DONE lasts one cycle with done high, -> IDLE; pc unchanged.
REQ-023 pc increments modulo IMEM_DEPTH (IMEM_DEPTH-1 wraps to 0); no HALT -> runs indefinitely.
REQ-024 stop high in any non-IDLE state -> IDLE at next edge; pending one-cycle pulses cleared; held fields retained; done not asserted; stop outranks all transitions.
REQ-025 start and stop high together in IDLE -> stop wins, stays IDLE.
REQ-026 Pulse outputs (ub_rd_start_in, sys_switch_in, done) never high two consecutive cycles.

Reset
REQ-027 rst asserted -> immediately: state IDLE, pc 0, every output 0 except instr_wr_ready 1; memory contents undefined, not cleared.
REQ-028 rst asserted mid-WAIT or mid-pulse -> pulse terminates immediately, no done.
REQ-029 After rst deassertion, first start follows REQ-015 timing.

Verification
REQ-030 Load [0]=ISSUE(transpose=1,ptr=0x005,addr=0x0010,row=4,col=2,pathway=0b1010,switch=0), [1]=HALT; start at pc0 edge k -> one ub_rd_start_in pulse at k+2 with those fields, done pulse at k+5, busy low after.
REQ-031 Load ISSUE, WAIT(5), ISSUE(switch=1), HALT -> second ub_rd_start_in 9 cycles after first, sys_switch_in coincident with second.
REQ-032 Write attempted while busy to addr 1 -> memory unchanged; instr_wr_ready low throughout run.
REQ-033 start_pc=IMEM_DEPTH-1 holding NOP, [0]=HALT -> pc wraps, done pulse follows.
REQ-034 stop asserted during WAIT(100) -> IDLE next edge, no done, held fields retain last ISSUE values.
REQ-035 rst asserted mid-ISSUE pulse -> all outputs 0 asynchronously, before next clock edge.
